// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer driving one shared external SubWord (4 S-boxes).
// Latency: round key 0 one cycle after start, then one round key per accepted beat; done 1 cycle after key 10.
// Backpressure: rk_valid/rk_ready handshake; rk, rk_index and sw_in hold while rk_ready is low.
module key_expand_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [31:0]  sw_in,
  input  logic [31:0]  sw_out,
  output logic [127:0] rk,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nxt;
  logic [127:0] rk_nxt;
  logic [3:0]   index_nxt;
  logic [7:0]   rcon, rcon_nxt;
  logic         done_nxt;
  logic [31:0]  t, n0, n1, n2, n3;

  // SubWord sees RotWord of the last word; pure wiring so it stays stable during stalls.
  assign sw_in    = {rk[23:0], rk[31:24]};
  assign rk_valid = (state == RUN);
  assign busy     = (state == RUN);

  // Next-state logic: load on start, advance one round per accepted beat, finish after round 10.
  always_comb begin
    state_nxt = state;
    rk_nxt    = rk;
    index_nxt = rk_index;
    rcon_nxt  = rcon;
    done_nxt  = 1'b0;
    // Next round key: XOR chain over the four words, seeded by SubWord result and rcon.
    t  = sw_out ^ {rcon, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    case (state)
      IDLE: begin
        if (start) begin
          rk_nxt    = key_in;
          index_nxt = 4'd0;
          rcon_nxt  = 8'h01;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here: no restart or key reload mid-run.
        if (rk_ready) begin
          if (rk_index == 4'd10) begin
            // Last key stays on rk; only the state and done change.
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            rk_nxt    = {n0, n1, n2, n3};
            index_nxt = rk_index + 4'd1;
            rcon_nxt  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset overrides everything and aborts a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rk       <= 128'h0;
      rk_index <= 4'd0;
      rcon     <= 8'h01;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rk       <= rk_nxt;
      rk_index <= index_nxt;
      rcon     <= rcon_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Testbench for key_expand_ctrl: supplies SubWord from a GF(2^8)-derived S-box table,
// models AES-128 key expansion with the textbook word recurrence, and checks every beat,
// stall, restart, reset abort and back-to-back behaviour.
module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic [31:0]  sw_in;
  logic [31:0]  sw_out;
  logic [127:0] rk;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [11];
  logic [127:0] obs_rk   [11];
  logic [7:0]   rcon_list [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  key_expand_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .sw_in    (sw_in),
    .sw_out   (sw_out),
    .rk       (rk),
    .rk_index (rk_index),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // External SubWord: four S-box lookups, combinational.
  assign sw_out = {sbox_tab[sw_in[31:24]], sbox_tab[sw_in[23:16]],
                   sbox_tab[sw_in[15:8]],  sbox_tab[sw_in[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = multiplicative inverse followed by the AES affine transform.
  task automatic build_sbox();
    logic [7:0] xb, yb, inv;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
  endfunction

  // Reference: 44-word expansion w[i] = w[i-4] ^ temp, grouped into 11 round keys.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0)
        temp = subw({temp[23:0], temp[31:24]}) ^ {rcon_list[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Starts an expansion from the current negedge and follows it to the done cycle.
  // Beats are matched against the model in order; done must arrive 12 cycles after
  // start plus one per stalled beat. Returns at the negedge where done is observed.
  task automatic run_key(input logic [127:0] key, input int stall_at, input int stall_len,
                         input int restart_at, input bit rand_ready, input bit start_at_end);
    int cyc, exp_idx, stalls, stalled;
    bit restarted, finished;
    logic [127:0] e;
    model_expand(key);
    start = 1'b1; key_in = key; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1; exp_idx = 0; stalls = 0; stalled = 0; restarted = 0; finished = 0;
    while (!finished) begin
      if (rk_valid === 1'b1) begin
        checks++;
        if (exp_idx > 10) begin
          errors++;
          $display("FAIL extra_beat: rk_index=%0d rk=%h, required no beat after index 10", rk_index, rk);
          finished = 1;
        end else begin
          e = exp_rk[exp_idx];
          if (rk !== e || rk_index !== exp_idx[3:0] || sw_in !== {e[23:0], e[31:24]} ||
              busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL beat cyc=%0d: rk=%h idx=%0d sw_in=%h busy=%b done=%b, required rk=%h idx=%0d sw_in=%h busy=1 done=0",
                     cyc, rk, rk_index, sw_in, busy, done, e, exp_idx, {e[23:0], e[31:24]});
          end
          obs_rk[exp_idx] = rk;
          rk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (exp_idx == stall_at && stalled < stall_len) begin
            rk_ready = 1'b0;
            stalled++;
          end
          if (exp_idx == restart_at && !restarted) begin
            start = 1'b1; key_in = ~key; restarted = 1;
          end
          if (start_at_end && exp_idx == 10 && rk_ready) begin
            start = 1'b1; key_in = ~key;
          end
          if (rk_ready) exp_idx++;
          else stalls++;
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || exp_idx != 11 || cyc != 12 + stalls) begin
          errors++;
          $display("FAIL done_timing: done=%b busy=%b at cycle %0d after %0d beats, required done=1 busy=0 at cycle %0d after 11 beats",
                   done, busy, cyc, exp_idx, 12 + stalls);
        end
        finished = 1;
      end
      if (!finished) begin
        if (cyc > 200) begin
          checks++; errors++;
          $display("FAIL timeout: no done within 200 cycles, rk_index=%0d", rk_index);
          finished = 1;
        end else begin
          @(negedge clk);
          start = 1'b0;
          cyc++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk !== 128'h0 ||
        rk_index !== 4'd0 || sw_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b rk=%h idx=%0d sw_in=%h, required all zero",
               rk_valid, busy, done, rk, rk_index, sw_in);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_fips_full();
    run_key(FIPS_KEY, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_rk[0] !== FIPS_KEY) begin
      errors++; $display("FAIL fips_r0: got %h, required %h", obs_rk[0], FIPS_KEY);
    end
    checks++;
    if (obs_rk[1] !== FIPS_R1) begin
      errors++; $display("FAIL fips_r1: got %h, required %h", obs_rk[1], FIPS_R1);
    end
    checks++;
    if (obs_rk[10] !== FIPS_R10) begin
      errors++; $display("FAIL fips_r10: got %h, required %h", obs_rk[10], FIPS_R10);
    end
    checks++;
    if (rk !== FIPS_R10) begin
      errors++; $display("FAIL rk_hold_after_done: got %h, required %h", rk, FIPS_R10);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: done=%b busy=%b valid=%b, required 0 0 0", done, busy, rk_valid);
    end
  endtask

  task automatic test_backpressure();
    run_key(FIPS_KEY, 4, 3, -1, 1'b0, 1'b0);
    checks++;
    if (obs_rk[10] !== FIPS_R10) begin
      errors++; $display("FAIL stall_r10: got %h, required %h", obs_rk[10], FIPS_R10);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    run_key(FIPS_KEY, -1, 0, 3, 1'b0, 1'b0);
    checks++;
    if (obs_rk[10] !== FIPS_R10) begin
      errors++; $display("FAIL restart_r10: got %h, required %h", obs_rk[10], FIPS_R10);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n;
    start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rk_valid === 1'b1 && rk_index === 4'd6) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL reach_index6: rk_index=%0d after 20 cycles, required 6", rk_index);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_index !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b idx=%0d, required 0 0 0 0", rk_valid, busy, done, rk_index);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_done: done=%b valid=%b, required 0 0", done, rk_valid);
    end
    run_key(128'h0, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_rk[1] !== ZERO_R1) begin
      errors++; $display("FAIL zero_key_r1: got %h, required %h", obs_rk[1], ZERO_R1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k2;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    // start during the final accept must be ignored; the next start lands on the done cycle.
    run_key(FIPS_KEY, -1, 0, -1, 1'b0, 1'b1);
    run_key(k2, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_rk[0] !== k2) begin
      errors++; $display("FAIL b2b_r0: got %h, required %h", obs_rk[0], k2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0] k;
    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_key(k, $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 10),
              1'b1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_in = 128'h0; rk_ready = 1'b0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_fips_full();
    test_backpressure();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expand_ctrl.md
# key_expand_ctrl

Sequencer for AES-128 key expansion around one external `SubWord` instance (four S-boxes). Accepts a 128-bit cipher key and produces the 11 round keys (round 0..10) in order, one per cycle when the consumer is ready. It drives the shared `SubWord` input with `RotWord` of the last word of the current round key, and combines the returned value with the round constant. Sits between key load and the round datapath's round-key register.

## Interface
- No parameters. AES-128 only.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin expansion; sampled only in IDLE.
- `key_in`  input  128  cipher key, sampled with `start`; w0 = `key_in[127:96]`, w3 = `key_in[31:0]`.
- `sw_in`  output  32  to SubWord `in`: `{rk[23:0], rk[31:24]}` (RotWord of w3), purely combinational from the `rk` register.
- `sw_out`  input  32  from SubWord `out`; combinational return, used in the same cycle.
- `rk`  output  128  current round key, registered.
- `rk_index`  output  4  round number of `rk`, 0..10.
- `rk_valid`  output  1  `rk` and `rk_index` are valid.
- `rk_ready`  input  1  consumer accepts the beat when `rk_valid & rk_ready`.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse after round key 10 is accepted.

## Operation
- States are IDLE and RUN.
- Registers:
  - `rk[127:0]`
  - `rk_index[3:0]`
  - `rcon[7:0]`
  - state
- IDLE:
  - `rk_valid` = 0 and `busy` = 0.
  - On `start`: `rk` ← `key_in`, `rk_index` ← 0, `rcon` ← 8'h01, go to RUN.
- RUN:
  - `rk_valid` = 1 and `busy` = 1.
  - No accept: all registers hold. `rk`, `rk_index` and `sw_in` stay stable while stalled.
  - Accept with `rk_index` < 10:
    - t = `sw_out` ^ {`rcon`, 24'h0}
    - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
    - `rk` ← {n0,n1,n2,n3}
    - `rk_index` ← `rk_index`+1
    - `rcon` ← xtime(`rcon`), i.e. (`rcon`<<1) ^ (`rcon[7]` ? 8'h1b : 0)
  - Accept with `rk_index` == 10: go to IDLE and pulse `done` on the next cycle. `rk` holds its last value.
- `rcon` sequence: 01,02,04,08,10,20,40,80,1b,36. Round i+1 uses the `rcon` value held while `rk_index` = i.
- `start` while in RUN is ignored; no restart and no key reload.
- `start` in the same cycle that round 10 is accepted is ignored. A new `start` is honoured from the next IDLE cycle onward, including the cycle in which `done` is high.
- `key_in` is don't-care except on the start cycle.
- All XORs are 32 bits wide. No other arithmetic.

## Timing
- Reset values: state IDLE, `rk` = 0, `rk_index` = 0, `rcon` = 8'h01, `rk_valid` = 0, `busy` = 0, `done` = 0. `sw_in` = 0 follows from `rk` = 0.
- `reset` wins over every other input in the same cycle. Reset in the middle of a run aborts it: no `done`, and `rk_valid` is 0 on the next cycle.
- `start` at edge t gives `rk_valid`=1 with round key 0 from cycle t+1.
- With `rk_ready` held high, rounds 0..10 appear on 11 consecutive cycles, t+1..t+11. `done`=1 at t+12, when `busy` and `rk_valid` are both 0.
- Each stall cycle delays every later beat and `done` by one cycle.
- Critical path: `rk` → `sw_in` → SubWord → `sw_out` → 4-deep XOR chain → `rk`, all within one cycle.

## Test plan
- **Reset:** assert `reset` for 2 cycles → `rk_valid`/`busy`/`done` = 0, `rk` = 0, `rk_index` = 0.
- **FIPS-197 vector, full throughput:** `key_in`=2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1.
  - Index 0 → 2b7e1516...4f3c.
  - Index 1 → a0fafe1788542cb123a339392a6c7605.
  - Index 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` exactly 12 cycles after `start`.
- **Backpressure:** same key with `rk_ready` low for 3 cycles at index 4 → `rk`/`rk_index`/`sw_in` frozen during the stall, index 5 value unchanged, `done` at cycle 15.
- **Restart ignored:** pulse `start` with a different key at index 3 → sequence continues with the original key; output identical to the full-throughput run.
- **Mid-run reset:** assert `reset` at index 6 → no `done`, `rk_valid`=0 next cycle. A following `start` with an all-zero key gives index 1 = 62636363626363636263636362636363.
- **Back-to-back:** `start` on the cycle `done` is high → new index 0 on the following cycle, no gap in `rcon` reinitialisation.
